flog_pack: RTL and testbench
============================

Name: flog_pack

Overview:
- Output stage of the bfloat16 log unit.
- Consumes the signed fixed-point log result produced by the log datapath (DIM=22 bits, COMMA_POS=14 fractional bits) and the upstream special-case bypass.
- Normalises, rounds to nearest-even and packs the value into a bfloat16 word.
- 2-stage elastic valid/ready pipeline; accepts one result per cycle when not back-pressured.

Parameters:
- DIM, 22, fixed-point input width (two's complement, from flog_pkg).
- COMMA_POS, 14, number of fractional bits of the input.
- EXP_WIDTH, 8, bfloat16 exponent width.
- FRACT_WIDTH, 7, bfloat16 mantissa width.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  upstream result valid
- in_ready_o  out  1  stage accepts input this cycle
- fix_i  in  DIM  signed fixed-point log value, LSB weight 2^-COMMA_POS
- spec_i  in  1  special case: bypass spec_val_i, ignore fix_i
- spec_val_i  in  16  precomputed special result (NaN, ±inf, ±0)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts result
- result_o  out  16  bfloat16 result {sign, exp[7:0], mant[6:0]}
- inexact_o  out  1  rounding discarded nonzero bits (0 on bypass)

Behaviour:
- One clock, clk. Reset asynchronous, active-low on rst_n.
- Reset values: s1_valid=0, out_valid_o=0, result_o=16'h0000, inexact_o=0. Data registers in stage 1 reset to 0.
- Handshake (both stages):
  - A transfer occurs when valid && ready.
  - Stage k loads when its register is empty or is being drained this cycle.
  - in_ready_o = !s1_valid || s2_load; s2_load = !out_valid_o || out_ready_i.
  - in_ready_o may depend combinationally on out_ready_i.
  - out_valid_o, result_o and inexact_o are stable while out_valid_o=1 && out_ready_i=0.
  - No loss, no duplication, order preserved.
- Latency: 2 cycles from accept to out_valid_o with no back-pressure. Throughput 1/cycle. Capacity 2 entries.
- Stage 1 (register):
  - sign = fix_i[DIM-1].
  - mag = |fix_i| as a DIM-bit unsigned; -2^21 gives mag=2^21, no overflow.
  - zero = (mag==0).
  - lz = leading zeros of mag, from flog_lzc.
  - Also register spec_i and spec_val_i.
- Stage 2 (register result):
  - norm = mag << lz, so the leading one sits at bit DIM-1.
  - mant = norm[20:14]; guard = norm[13]; sticky = |norm[12:0].
  - exp = (DIM-1-lz) - COMMA_POS + BIAS, range 113..134. Always normal: no overflow, no denormals.
  - Round up iff guard && (sticky || mant[0]).
  - On mantissa carry-out: mant=0, exp+1.
  - inexact = guard || sticky.
- Priority in stage 2:
  - spec → result=spec_val, inexact=0.
  - else zero → result=16'h0000 (+0, even if sign bit set), inexact=0.
  - else normal packed value.
- Boundaries:
  - Simultaneous input accept and output drain when both stages are full: stage 2 ← stage 1, stage 1 ← input, in the same cycle.
  - Reset mid-operation discards all in-flight entries; out_valid_o drops asynchronously.

Decomposition:
- flog_pkg gains:
  - FIX_WIDTH (=DIM).
  - EXP_MIN_FIX = BIAS - COMMA_POS.
  - PLUS_ZERO, MINUS_INF, QNAN constants (currently commented out; enable them).
  - Packed struct bf16_t {s, exp, mant}.
- One sub-module: flog_lzc, a parameterised combinational leading-zero counter (width DIM, output $clog2(DIM) bits). Shared with the upstream denormal path.

Test Plan:
- fix_i=22'h004000 (1.0), spec_i=0 → after 2 cycles result_o=16'h3F80, inexact_o=0.
- fix_i=22'h002C5C (ln2 ≈ 0.693) → result_o=16'h3F31, inexact_o=1. Then fix_i=22'h3FC000 (-1.0) → 16'hBF80. Then fix_i=22'h200000 (-128) → 16'hC300.
- Rounding:
  - fix_i=22'h007FC0 (tie, mant odd) → 16'h4000 (carry into exponent), inexact=1.
  - fix_i=22'h004040 (tie, mant even) → 16'h3F80, inexact=1.
- Bypass and zero:
  - spec_i=1, spec_val_i=16'hFF80 with fix_i=22'h004000 → 16'hFF80, inexact=0.
  - fix_i=0 → 16'h0000.
- Back-pressure:
  - Hold out_ready_i=0 and push A=1.0, B=-1.0, C=ln2. A and B are accepted; in_ready_o=0 with C pending.
  - result_o holds 16'h3F80 stable.
  - Release out_ready_i → outputs 3F80, BF80, 3F31 on consecutive cycles.
  - Random valid/ready scoreboard over 10k items: no drops or reorders.
- Reset: assert rst_n=0 with both stages full, asynchronously mid-cycle → out_valid_o=0 and in_ready_o=1 immediately; no stale output after release.

Source files
------------

// File: rtl/flog_pkg.sv
// Shared types and constants for the bfloat16 log unit.
// Fixed-point results are two's complement, DIM bits, COMMA_POS fractional bits.
package flog_pkg;

  localparam int DIM         = 22;
  localparam int COMMA_POS   = 14;
  localparam int EXP_WIDTH   = 8;
  localparam int FRACT_WIDTH = 7;
  localparam int BIAS        = 127;

  localparam int FIX_WIDTH   = DIM;
  localparam int EXP_MIN_FIX = BIAS - COMMA_POS;
  localparam int LZC_WIDTH   = $clog2(DIM);
  localparam int BF16_WIDTH  = 1 + EXP_WIDTH + FRACT_WIDTH;

  localparam logic [BF16_WIDTH-1:0] PLUS_ZERO = 16'h0000;
  localparam logic [BF16_WIDTH-1:0] PLUS_INF  = 16'h7F80;
  localparam logic [BF16_WIDTH-1:0] MINUS_INF = 16'hFF80;
  localparam logic [BF16_WIDTH-1:0] QNAN      = 16'h7FC0;

  typedef struct packed {
    logic                   s;
    logic [EXP_WIDTH-1:0]   exp;
    logic [FRACT_WIDTH-1:0] mant;
  } bf16_t;

  // Stage-1 payload: magnitude plus everything stage 2 needs to normalise it.
  typedef struct packed {
    logic                  spec;
    logic [BF16_WIDTH-1:0] spec_val;
    logic                  zero;
    logic                  sign;
    logic [LZC_WIDTH-1:0]  lz;
    logic [FIX_WIDTH-1:0]  mag;
  } s1_t;

  // Magnitude of a two's complement value; the most negative input maps to 2^(W-1) unsigned.
  function automatic logic [FIX_WIDTH-1:0] fix_abs(input logic [FIX_WIDTH-1:0] v);
    return v[FIX_WIDTH-1] ? ((~v) + FIX_WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/flog_lzc.sv
// Combinational leading-zero counter; an all-zero input reports 0, callers flag zero separately.
// No state, no handshake.
module flog_lzc #(
  parameter int WIDTH = 22,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CW-1:0]    cnt_o
);

  // Later iterations win, so the highest set bit determines the count.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) cnt_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/flog_pack.sv
// Normalise, round-to-nearest-even and pack the fixed-point log result into bfloat16; 2-cycle latency.
// Two-entry elastic valid/ready pipeline: each stage refills in the cycle it drains.
module flog_pack
  import flog_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [FIX_WIDTH-1:0]  fix_i,
  input  logic                  spec_i,
  input  logic [BF16_WIDTH-1:0] spec_val_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [BF16_WIDTH-1:0] result_o,
  output logic                  inexact_o
);

  localparam int GRD_POS = DIM - 2 - FRACT_WIDTH;

  logic                 s1_valid_q;
  s1_t                  s1_d, s1_q;
  logic                 out_valid_q;
  bf16_t                result_d, result_q;
  logic                 inexact_d, inexact_q;

  logic                 s1_load, s2_load;
  logic [FIX_WIDTH-1:0] mag_in;
  logic [LZC_WIDTH-1:0] lz_in;

  assign s2_load    = !out_valid_q || out_ready_i;
  assign s1_load    = !s1_valid_q || s2_load;
  assign in_ready_o = s1_load;

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign inexact_o   = inexact_q;

  assign mag_in = fix_abs(fix_i);

  flog_lzc #(
    .WIDTH(FIX_WIDTH),
    .CW   (LZC_WIDTH)
  ) u_lzc (
    .in_i (mag_in),
    .cnt_o(lz_in)
  );

  always_comb begin
    s1_d          = '0;
    s1_d.spec     = spec_i;
    s1_d.spec_val = spec_val_i;
    s1_d.sign     = fix_i[FIX_WIDTH-1];
    s1_d.mag      = mag_in;
    s1_d.zero     = (mag_in == '0);
    s1_d.lz       = lz_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) s1_q <= s1_d;
    end
  end

  logic [DIM-2:0]         norm;
  logic [FRACT_WIDTH-1:0] mant_raw;
  logic                   guard, sticky, round_up;
  logic [FRACT_WIDTH:0]   mant_sum;
  logic [EXP_WIDTH-1:0]   exp_raw;

  // The leading one lands on bit DIM-1 after the shift and is implicit, so it is dropped.
  always_comb begin
    norm     = (DIM-1)'(s1_q.mag << s1_q.lz);
    mant_raw = norm[DIM-2 -: FRACT_WIDTH];
    guard    = norm[GRD_POS];
    sticky   = |norm[GRD_POS-1:0];
    round_up = guard && (sticky || mant_raw[0]);
    mant_sum = {1'b0, mant_raw} + {{FRACT_WIDTH{1'b0}}, round_up};
    exp_raw  = EXP_WIDTH'(EXP_MIN_FIX + DIM - 1) - EXP_WIDTH'(s1_q.lz);

    result_d      = '0;
    inexact_d     = 1'b0;
    if (s1_q.spec) begin
      result_d = s1_q.spec_val;
    end else if (s1_q.zero) begin
      result_d = PLUS_ZERO;
    end else begin
      result_d.s    = s1_q.sign;
      result_d.exp  = exp_raw + {{(EXP_WIDTH-1){1'b0}}, mant_sum[FRACT_WIDTH]};
      result_d.mant = mant_sum[FRACT_WIDTH-1:0];
      inexact_d     = guard || sticky;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      inexact_q   <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q  <= result_d;
        inexact_q <= inexact_d;
      end
    end
  end

endmodule

// File: tb/tb_flog_pack.sv
// Bench for flog_pack: directed vector table, back-pressure and reset sequences, random scoreboard.
module tb_flog_pack;
  import flog_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [21:0] fix_i = '0;
  logic        spec_i = 1'b0;
  logic [15:0] spec_val_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [15:0] result_o;
  logic        inexact_o;

  always #5 clk = ~clk;

  flog_pack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .fix_i      (fix_i),
    .spec_i     (spec_i),
    .spec_val_i (spec_val_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .result_o   (result_o),
    .inexact_o  (inexact_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: value = fix / 2^14, rounded to 8 significant bits, ties to even.
  function automatic logic [16:0] ref_model(input logic [21:0] fix, input logic spec,
                                             input logic [15:0] sval);
    int v, mag, e, sh, q, rem, half;
    logic s;
    logic [7:0] ex;
    logic [6:0] mt;
    if (spec) return {1'b0, sval};
    v = int'($signed(fix));
    if (v == 0) return 17'h0;
    s   = (v < 0);
    mag = s ? -v : v;
    e   = 0;
    while ((mag >> (e + 1)) != 0) e++;
    sh  = e - 7;
    rem = 0;
    if (sh <= 0) begin
      q = mag << (-sh);
    end else begin
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
    end
    if (q == 256) begin
      q = 128;
      e++;
    end
    ex = 8'(e - COMMA_POS + BIAS);
    mt = 7'(q - 128);
    return {(rem != 0), s, ex, mt};
  endfunction

  typedef struct {
    logic [21:0] fix;
    logic        spec;
    logic [15:0] sval;
    logic [15:0] res;
    logic        inx;
  } vec_t;

  vec_t tbl[8];
  logic [16:0] expq[$];

  initial begin
    tbl[0] = '{22'h004000, 1'b0, 16'h0000, 16'h3F80, 1'b0};
    tbl[1] = '{22'h002C5C, 1'b0, 16'h0000, 16'h3F31, 1'b1};
    tbl[2] = '{22'h3FC000, 1'b0, 16'h0000, 16'hBF80, 1'b0};
    tbl[3] = '{22'h200000, 1'b0, 16'h0000, 16'hC300, 1'b0};
    tbl[4] = '{22'h007FC0, 1'b0, 16'h0000, 16'h4000, 1'b1};
    tbl[5] = '{22'h004040, 1'b0, 16'h0000, 16'h3F80, 1'b1};
    tbl[6] = '{22'h004000, 1'b1, 16'hFF80, 16'hFF80, 1'b0};
    tbl[7] = '{22'h000000, 1'b0, 16'h0000, 16'h0000, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_result", 32'(result_o), 32'h0000);
    chk("rst_inexact", 32'(inexact_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);

    // Directed table, one item at a time, latency checked
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid_i = 1'b1;
      fix_i      = tbl[i].fix;
      spec_i     = tbl[i].spec;
      spec_val_i = tbl[i].sval;
      #1 chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready_o), 32'd1);
      @(negedge clk);
      in_valid_i = 1'b0;
      spec_i     = 1'b0;
      #1 chk($sformatf("tbl%0d_lat1", i), 32'(out_valid_o), 32'd0);
      @(negedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid_o), 32'd1);
      chk($sformatf("tbl%0d_result", i), 32'(result_o), 32'(tbl[i].res));
      chk($sformatf("tbl%0d_inexact", i), 32'(inexact_o), 32'(tbl[i].inx));
    end

    // Back-pressure: A, B fill both stages, C stalls
    @(negedge clk);
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    fix_i       = 22'h004000;
    @(negedge clk);
    fix_i = 22'h3FC000;
    @(negedge clk);
    fix_i = 22'h002C5C;
    #1 chk("bp_c_blocked", 32'(in_ready_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp_hold%0d", k), 32'({out_valid_o, in_ready_o, result_o}), {15'd0, 2'b10, 16'h3F80});
    end
    @(negedge clk);
    out_ready_i = 1'b1;
    #1;
    chk("bp_c_accept", 32'(in_ready_o), 32'd1);
    chk("bp_out0", 32'({out_valid_o, result_o}), {15'd0, 1'b1, 16'h3F80});
    @(negedge clk);
    in_valid_i = 1'b0;
    #1 chk("bp_out1", 32'({out_valid_o, result_o}), {15'd0, 1'b1, 16'hBF80});
    @(negedge clk);
    #1 chk("bp_out2", 32'({out_valid_o, result_o}), {15'd0, 1'b1, 16'h3F31});
    @(negedge clk);
    #1 chk("bp_empty", 32'(out_valid_o), 32'd0);

    // Random valid/ready scoreboard
    begin
      int   pushed = 0;
      int   cycles = 0;
      logic hold = 1'b0;
      logic prev_stall = 1'b0;
      logic [16:0] prev_out = '0;
      logic [16:0] exp_v;
      while ((pushed < 10000 || expq.size() != 0) && cycles < 60000) begin
        @(negedge clk);
        if (!hold) begin
          if (pushed < 10000 && $urandom_range(3) != 0) begin
            in_valid_i = 1'b1;
            spec_i     = 1'b0;
            spec_val_i = 16'($urandom);
            case ($urandom_range(5))
              0: fix_i = 22'($urandom);
              1: fix_i = 22'($signed(32'($urandom_range(511)) - 256));
              2: fix_i = ($urandom_range(1) != 0) ? 22'h200000 : 22'h000000;
              3: fix_i = 22'(($urandom & 32'h3FFF80) | 32'h40) >> $urandom_range(8);
              4: spec_i = 1'b1;
              default: fix_i = 22'($urandom) >> $urandom_range(21);
            endcase
          end else begin
            in_valid_i = 1'b0;
          end
        end
        out_ready_i = ($urandom_range(3) != 0);
        #1;
        if (prev_stall)
          chk("rand_stall_hold", 32'({out_valid_o, inexact_o, result_o}), 32'({1'b1, prev_out}));
        if (out_valid_o && out_ready_i) begin
          if (expq.size() == 0) begin
            n_checks++;
            $display("FAIL rand_spurious: got output %h, expected none", result_o);
          end else begin
            exp_v = expq.pop_front();
            chk("rand_item", 32'({inexact_o, result_o}), 32'(exp_v));
          end
        end
        if (in_valid_i && in_ready_o) begin
          expq.push_back(ref_model(fix_i, spec_i, spec_val_i));
          pushed++;
        end
        hold       = in_valid_i && !in_ready_o;
        prev_stall = out_valid_o && !out_ready_i;
        prev_out   = {inexact_o, result_o};
        cycles++;
      end
      if (cycles >= 60000) begin
        n_checks++;
        $display("FAIL rand_timeout: pushed %0d, %0d left, expected all drained", pushed, expq.size());
      end
    end

    // Asynchronous reset with both stages full
    @(negedge clk);
    in_valid_i  = 1'b1;
    spec_i      = 1'b0;
    out_ready_i = 1'b0;
    fix_i       = 22'h004000;
    @(negedge clk);
    fix_i = 22'h3FC000;
    @(negedge clk);
    in_valid_i = 1'b0;
    #1 chk("arst_full", 32'({out_valid_o, in_ready_o}), 32'b10);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_o), 32'd0);
    chk("arst_in_ready", 32'(in_ready_o), 32'd1);
    chk("arst_result", 32'(result_o), 32'h0000);
    @(negedge clk);
    rst_n       = 1'b1;
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk($sformatf("arst_no_stale%0d", k), 32'(out_valid_o), 32'd0);
    end
    @(negedge clk);
    in_valid_i = 1'b1;
    fix_i      = 22'h002C5C;
    @(negedge clk);
    in_valid_i = 1'b0;
    @(negedge clk);
    #1 chk("arst_after", 32'({out_valid_o, inexact_o, result_o}), {14'd0, 2'b11, 16'h3F31});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
